fetch_sequencer: RTL and testbench

Instruction fetch and program-counter sequencer for the PISA core. It issues instruction-memory reads, latches each returned instruction, and presents the opcode and operand fields to the control unit. After the control unit's registered control word settles, it resolves halt and jump decisions and advances the PC. It is the producer of the opcode stream and the consumer of the halt, jump-source and jump-condition fields.

---
 rtl/pisa_pkg.sv | 42 ++++
 rtl/branch_resolve.sv | 54 +++++
 rtl/fetch_sequencer.sv | 109 ++++++++++
 tb/tb_fetch_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pisa_pkg.sv
// Shared PISA core definitions: control-word encodings, instruction field
// positions and the fetch sequencer state type.
package pisa_pkg;

    typedef enum logic [1:0] {
        JMP_NONE  = 2'd0,
        JMP_RDEST = 2'd1,
        JMP_IMM   = 2'd2,
        JMP_ADDR  = 2'd3
    } jump_src_enum_t;

    typedef enum logic [2:0] {
        JC_ALWAYS   = 3'b000,
        JC_NEVER_1  = 3'b001,
        JC_ZERO     = 3'b010,
        JC_NOT_ZERO = 3'b011,
        JC_NEG      = 3'b100,
        JC_NOT_NEG  = 3'b101,
        JC_NEVER_6  = 3'b110,
        JC_NEVER_7  = 3'b111
    } jump_condition_enum_t;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_WAIT    = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALTED  = 3'd4
    } fetch_state_t;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 24;
    localparam int unsigned RDEST_MSB  = 23;
    localparam int unsigned RDEST_LSB  = 20;
    localparam int unsigned RSRC1_MSB  = 19;
    localparam int unsigned RSRC1_LSB  = 16;
    localparam int unsigned RSRC2_MSB  = 15;
    localparam int unsigned RSRC2_LSB  = 12;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned IMM_LSB    = 0;

endpackage

// File: rtl/branch_resolve.sv
// Combinational jump resolution: evaluates the jump condition against the ALU
// flags and selects the jump target for the current control word.
module branch_resolve
    import pisa_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic [1:0]            jmp_src,
    input  logic [2:0]            jump_condition,
    input  logic                  flag_zero,
    input  logic                  flag_negative,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [15:0]           immediate,
    input  logic [ADDR_WIDTH-1:0] rdest_value,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic                  taken,
    output logic [ADDR_WIDTH-1:0] target
);

    jump_src_enum_t          w_src;
    jump_condition_enum_t    w_cond;
    logic                    w_cond_met;
    logic [ADDR_WIDTH-1:0]   w_imm_ext;

    assign w_src     = jump_src_enum_t'(jmp_src);
    assign w_cond    = jump_condition_enum_t'(jump_condition);
    // Sign-extend (or truncate) the immediate to the address width; the add wraps.
    assign w_imm_ext = ADDR_WIDTH'($signed(immediate));

    always_comb begin
        w_cond_met = 1'b0;
        case (w_cond)
            JC_ALWAYS:   w_cond_met = 1'b1;
            JC_ZERO:     w_cond_met = flag_zero;
            JC_NOT_ZERO: w_cond_met = ~flag_zero;
            JC_NEG:      w_cond_met = flag_negative;
            JC_NOT_NEG:  w_cond_met = ~flag_negative;
            default:     w_cond_met = 1'b0;
        endcase
    end

    assign taken = (w_src != JMP_NONE) && w_cond_met;

    always_comb begin
        target = pc;
        case (w_src)
            JMP_RDEST: target = rdest_value;
            JMP_IMM:   target = pc + w_imm_ext;
            JMP_ADDR:  target = jump_addr;
            default:   target = pc;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// PISA instruction fetch / PC sequencer: issues single outstanding imem reads,
// holds the instruction register and resolves halt and jumps after EXECUTE.
module fetch_sequencer
    import pisa_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [31:0]           imem_rsp_data,
    output logic [7:0]            opcode,
    output logic [3:0]            rdest_idx,
    output logic [3:0]            rsrc1_idx,
    output logic [3:0]            rsrc2_idx,
    output logic [15:0]           immediate,
    input  logic                  halt,
    input  logic [1:0]            jmp_src,
    input  logic [2:0]            jump_condition,
    input  logic                  flag_zero,
    input  logic                  flag_negative,
    input  logic [ADDR_WIDTH-1:0] rdest_value,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    input  logic                  ex_busy,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  insn_valid,
    output logic                  halted
);

    fetch_state_t          r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [31:0]           r_insn;
    logic                  w_taken;
    logic [ADDR_WIDTH-1:0] w_target;

    branch_resolve #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_branch_resolve (
        .jmp_src       (jmp_src),
        .jump_condition(jump_condition),
        .flag_zero     (flag_zero),
        .flag_negative (flag_negative),
        .pc            (r_pc),
        .immediate     (r_insn[IMM_MSB:IMM_LSB]),
        .rdest_value   (rdest_value),
        .jump_addr     (jump_addr),
        .taken         (w_taken),
        .target        (w_target)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_insn  <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_req_ready) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_insn  <= imem_rsp_data;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    if (!ex_busy) begin
                        if (halt) begin
                            r_state <= ST_HALTED;
                        end else begin
                            r_pc    <= w_taken ? w_target : r_pc + ADDR_WIDTH'(1);
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    // Reset state is FETCH, so the request is gated by rst_n to read 0 in reset.
    assign imem_req_valid = (r_state == ST_FETCH) && rst_n;
    assign imem_addr      = r_pc;
    assign pc             = r_pc;
    assign insn_valid     = (r_state == ST_DECODE) || (r_state == ST_EXECUTE);
    assign halted         = (r_state == ST_HALTED);

    assign opcode    = r_insn[OPCODE_MSB:OPCODE_LSB];
    assign rdest_idx = r_insn[RDEST_MSB:RDEST_LSB];
    assign rsrc1_idx = r_insn[RSRC1_MSB:RSRC1_LSB];
    assign rsrc2_idx = r_insn[RSRC2_MSB:RSRC2_LSB];
    assign immediate = r_insn[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer: sequential fetch, stalls,
// relative/absolute/conditional jumps, PC wrap, reset during WAIT and halt.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [7:0]  opcode;
    logic [3:0]  rdest_idx;
    logic [3:0]  rsrc1_idx;
    logic [3:0]  rsrc2_idx;
    logic [15:0] immediate;
    logic        halt;
    logic [1:0]  jmp_src;
    logic [2:0]  jump_condition;
    logic        flag_zero;
    logic        flag_negative;
    logic [15:0] rdest_value;
    logic [15:0] jump_addr;
    logic        ex_busy;
    logic [15:0] pc;
    logic        insn_valid;
    logic        halted;

    int          vectors;
    int          miscompares;
    int unsigned cyc;

    fetch_sequencer #(
        .ADDR_WIDTH(16),
        .RESET_PC  (16'h0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .opcode        (opcode),
        .rdest_idx     (rdest_idx),
        .rsrc1_idx     (rsrc1_idx),
        .rsrc2_idx     (rsrc2_idx),
        .immediate     (immediate),
        .halt          (halt),
        .jmp_src       (jmp_src),
        .jump_condition(jump_condition),
        .flag_zero     (flag_zero),
        .flag_negative (flag_negative),
        .rdest_value   (rdest_value),
        .jump_addr     (jump_addr),
        .ex_busy       (ex_busy),
        .pc            (pc),
        .insn_valid    (insn_valid),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] insn;
        logic [1:0]  src;
        logic [2:0]  cond;
        logic        fz;
        logic        fn;
        logic [15:0] rdv;
        logic [15:0] ja;
        logic [15:0] exp_addr;
    } jump_vec_t;

    // Runs one instruction with a zero-wait memory. Called and returns at a
    // falling edge; on return the DUT is in FETCH (or HALTED).
    task automatic do_insn(input logic [31:0] insn, input logic h, input logic [1:0] src,
                           input logic [2:0] cond, input logic fz, input logic fn,
                           input logic [15:0] rdv, input logic [15:0] ja, input int busy,
                           output logic [15:0] addr, output int unsigned stamp);
        int n;
        n     = 0;
        addr  = 16'hxxxx;
        stamp = 0;
        while (imem_req_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (imem_req_valid !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL fetch_timeout: imem_req_valid=%b after %0d cycles, required 1", imem_req_valid, n);
            return;
        end
        addr  = imem_addr;
        stamp = cyc;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = insn;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hFFFF_FFFF;
        halt           = h;
        jmp_src        = src;
        jump_condition = cond;
        flag_zero      = fz;
        flag_negative  = fn;
        rdest_value    = rdv;
        jump_addr      = ja;
        ex_busy        = (busy > 0);
        @(negedge clk);
        repeat (busy) @(negedge clk);
        ex_busy = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid: got %b required 0", imem_req_valid); end
        vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL rst_pc: got %h required 0000", pc); end
        vectors++; if (opcode !== 8'h00 || immediate !== 16'h0000) begin miscompares++; $display("FAIL rst_ir: opcode %h imm %h required 00 0000", opcode, immediate); end
        vectors++; if (insn_valid !== 1'b0 || halted !== 1'b0) begin miscompares++; $display("FAIL rst_status: insn_valid %b halted %b required 0 0", insn_valid, halted); end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        logic [15:0] a0, a1, a2;
        int unsigned s0, s1, s2;
        do_insn(32'h0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 0, a0, s0);
        do_insn(32'h0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 0, a1, s1);
        do_insn(32'h0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 0, a2, s2);
        vectors++; if (a0 !== 16'h0000) begin miscompares++; $display("FAIL seq_addr0: got %h required 0000", a0); end
        vectors++; if (a1 !== 16'h0001) begin miscompares++; $display("FAIL seq_addr1: got %h required 0001", a1); end
        vectors++; if (a2 !== 16'h0002) begin miscompares++; $display("FAIL seq_addr2: got %h required 0002", a2); end
        vectors++; if (s1 - s0 !== 4 || s2 - s1 !== 4) begin miscompares++; $display("FAIL seq_spacing: got %0d %0d cycles required 4 4", s1 - s0, s2 - s1); end
        vectors++; if (pc !== 16'h0003) begin miscompares++; $display("FAIL seq_pc: got %h required 0003", pc); end
    endtask

    task automatic test_fields();
        logic [15:0] a;
        int unsigned s;
        do_insn(32'hA512_3456, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 0, a, s);
        vectors++; if (opcode !== 8'hA5) begin miscompares++; $display("FAIL fld_opcode: got %h required a5", opcode); end
        vectors++; if (rdest_idx !== 4'h1 || rsrc1_idx !== 4'h2 || rsrc2_idx !== 4'h3) begin miscompares++; $display("FAIL fld_regs: got %h %h %h required 1 2 3", rdest_idx, rsrc1_idx, rsrc2_idx); end
        vectors++; if (immediate !== 16'h3456) begin miscompares++; $display("FAIL fld_imm: got %h required 3456", immediate); end
        vectors++; if (insn_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 16'h0004) begin miscompares++; $display("FAIL fld_next_fetch: insn_valid %b req %b addr %h required 0 1 0004", insn_valid, imem_req_valid, imem_addr); end
    endtask

    task automatic test_stall();
        logic [15:0] a;
        int unsigned s;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (imem_req_valid !== 1'b1 || imem_addr !== 16'h0004 || pc !== 16'h0004) begin miscompares++; $display("FAIL stall_hold%0d: req %b addr %h pc %h required 1 0004 0004", i, imem_req_valid, imem_addr, pc); end
            @(negedge clk);
        end
        do_insn(32'h0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 0, a, s);
        vectors++; if (a !== 16'h0004 || pc !== 16'h0005) begin miscompares++; $display("FAIL stall_release: addr %h pc %h required 0004 0005", a, pc); end
    endtask

    task automatic test_ex_busy();
        logic [15:0] a0, a1;
        int unsigned s0, s1;
        do_insn(32'h0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 3, a0, s0);
        do_insn(32'h0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 0, a1, s1);
        vectors++; if (s1 - s0 !== 7) begin miscompares++; $display("FAIL busy_spacing: got %0d cycles required 7", s1 - s0); end
        vectors++; if (a0 !== 16'h0005 || a1 !== 16'h0006 || pc !== 16'h0007) begin miscompares++; $display("FAIL busy_pc: addrs %h %h pc %h required 0005 0006 0007", a0, a1, pc); end
    endtask

    task automatic test_jumps();
        jump_vec_t   tbl[12];
        logic [15:0] a;
        int unsigned s;
        tbl[0]  = '{32'h3100_0000, 2'd3, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'h0010};
        tbl[1]  = '{32'h3200_FFF0, 2'd2, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        tbl[2]  = '{32'h3300_0000, 2'd3, 3'b000, 1'b0, 1'b0, 16'h0000, 16'hFFFE, 16'hFFFE};
        tbl[3]  = '{32'h3400_0005, 2'd2, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0003};
        tbl[4]  = '{32'h3500_0010, 2'd2, 3'b010, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0013};
        tbl[5]  = '{32'h3600_0010, 2'd2, 3'b010, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0014};
        tbl[6]  = '{32'h3700_0010, 2'd2, 3'b110, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0015};
        tbl[7]  = '{32'h3800_0000, 2'd1, 3'b011, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h1234};
        tbl[8]  = '{32'h3900_0000, 2'd3, 3'b100, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 16'hFFFF};
        tbl[9]  = '{32'h3A00_0000, 2'd3, 3'b101, 1'b0, 1'b1, 16'h0000, 16'h0100, 16'h0000};
        tbl[10] = '{32'h3B00_0000, 2'd3, 3'b001, 1'b1, 1'b1, 16'h0000, 16'h0100, 16'h0001};
        tbl[11] = '{32'h3C00_0000, 2'd0, 3'b000, 1'b1, 1'b1, 16'h0000, 16'h0100, 16'h0002};
        for (int i = 0; i < 12; i++) begin
            do_insn(tbl[i].insn, 1'b0, tbl[i].src, tbl[i].cond, tbl[i].fz, tbl[i].fn, tbl[i].rdv, tbl[i].ja, 0, a, s);
            vectors++; if (imem_req_valid !== 1'b1 || imem_addr !== tbl[i].exp_addr) begin miscompares++; $display("FAIL jump%0d: req %b addr %h required 1 %h", i, imem_req_valid, imem_addr, tbl[i].exp_addr); end
        end
    endtask

    task automatic test_reset_in_wait();
        logic [15:0] a;
        int unsigned s;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++; if (pc !== 16'h0000 || opcode !== 8'h00) begin miscompares++; $display("FAIL rstwait_async: pc %h opcode %h required 0000 00", pc, opcode); end
        @(negedge clk);
        rst_n          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        vectors++; if (opcode !== 8'h00 || immediate !== 16'h0000) begin miscompares++; $display("FAIL rstwait_ir: opcode %h imm %h required 00 0000", opcode, immediate); end
        vectors++; if (imem_req_valid !== 1'b1 || imem_addr !== 16'h0000 || insn_valid !== 1'b0) begin miscompares++; $display("FAIL rstwait_state: req %b addr %h insn_valid %b required 1 0000 0", imem_req_valid, imem_addr, insn_valid); end
        do_insn(32'h0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 0, a, s);
        vectors++; if (a !== 16'h0000 || pc !== 16'h0001) begin miscompares++; $display("FAIL rstwait_resume: addr %h pc %h required 0000 0001", a, pc); end
    endtask

    task automatic test_halt();
        logic [15:0] a;
        int unsigned s;
        do_insn(32'hFF00_0000, 1'b1, 2'd3, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0055, 0, a, s);
        vectors++; if (halted !== 1'b1 || insn_valid !== 1'b0) begin miscompares++; $display("FAIL halt_flag: halted %b insn_valid %b required 1 0", halted, insn_valid); end
        vectors++; if (pc !== 16'h0001) begin miscompares++; $display("FAIL halt_pc: got %h required 0001", pc); end
        for (int i = 0; i < 5; i++) begin
            imem_req_ready = 1'b1;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'h1234_5678;
            vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL halt_noreq%0d: got %b required 0", i, imem_req_valid); end
            @(negedge clk);
        end
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        vectors++; if (opcode !== 8'hFF || pc !== 16'h0001 || halted !== 1'b1) begin miscompares++; $display("FAIL halt_hold: opcode %h pc %h halted %b required ff 0001 1", opcode, pc, halted); end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        halt           = 1'b0;
        jmp_src        = 2'd0;
        jump_condition = 3'd0;
        flag_zero      = 1'b0;
        flag_negative  = 1'b0;
        rdest_value    = 16'h0;
        jump_addr      = 16'h0;
        ex_busy        = 1'b0;
        test_reset();
        test_sequential();
        test_fields();
        test_stall();
        test_ex_busy();
        test_jumps();
        test_reset_in_wait();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
